// File: rtl/ysyx_22050039_pkg.sv
// Shared types and constants for the ysyx_22050039 fetch slice.
package ysyx_22050039_pkg;

  localparam int INST_W = 32;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_OUT   = 2'd2,
    S_FAULT = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_22050039_reg.sv
// Register with enable and asynchronous active-low reset to RESET_VAL.
module ysyx_22050039_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VAL;
    end else if (en) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/ysyx_22050039_ifu.sv
// Multi-cycle instruction fetch unit: REQ -> WAIT -> OUT, redirect has top priority.
// Define YSYX_22050039_IFU_ALIGN_CHECK_EN to trap misaligned PCs in S_FAULT.
module ysyx_22050039_ifu
  import ysyx_22050039_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              misalign,
  output ifu_state_e        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends combinationally on the matching ready.

  ifu_state_e        state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              pc_en;
  logic [INST_W-1:0] inst_q;
  logic              inst_en;
  logic              kill_q, kill_d;

  ysyx_22050039_reg #(.WIDTH(XLEN), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk(clk), .rst_n(rst), .en(pc_en), .d(pc_d), .q(pc_q)
  );

  ysyx_22050039_reg #(.WIDTH(INST_W), .RESET_VAL('0)) u_inst_reg (
    .clk(clk), .rst_n(rst), .en(inst_en), .d(imem_resp_data), .q(inst_q)
  );

  ysyx_22050039_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_kill_reg (
    .clk(clk), .rst_n(rst), .en(1'b1), .d(kill_d), .q(kill_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc_en   = 1'b0;
    inst_en = 1'b0;
    kill_d  = kill_q;
    unique case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          pc_en = 1'b1;
          pc_d  = redirect_pc;
          // The request already accepted is for the stale PC; drop its response.
          if (imem_req_ready) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_en = 1'b1;
          pc_d  = redirect_pc;
          if (imem_resp_valid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (kill_q) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            inst_en = 1'b1;
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          pc_en   = 1'b1;
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (inst_ready) begin
          pc_en   = 1'b1;
          pc_d    = pc_q + XLEN'(4);
          state_d = S_REQ;
        end
      end
`ifdef YSYX_22050039_IFU_ALIGN_CHECK_EN
      S_FAULT: begin
        if (redirect_valid) begin
          pc_en   = 1'b1;
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end
      end
`endif
      default: state_d = S_REQ;
    endcase
`ifdef YSYX_22050039_IFU_ALIGN_CHECK_EN
    // Alignment is judged on the PC that S_REQ would present next cycle.
    if (state_d == S_REQ && pc_d[1:0] != 2'b00) begin
      state_d = S_FAULT;
    end
`endif
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_OUT);
  assign inst           = inst_valid ? inst_q : '0;
  assign inst_pc        = inst_valid ? pc_q : '0;
  assign dbg_state      = state_q;

`ifdef YSYX_22050039_IFU_ALIGN_CHECK_EN
  assign misalign = (state_q == S_FAULT);
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// Directed self-checking bench for ysyx_22050039_ifu.
module tb_ysyx_22050039_ifu;
  import ysyx_22050039_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        misalign;
  ifu_state_e  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_pc;

  always #5 clk = ~clk;

  ysyx_22050039_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .misalign(misalign), .dbg_state(dbg_state)
  );

  task automatic test_reset();
    rst = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk); @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b1) begin n_errors++; $display("FAIL reset_req_valid: got %b want 1", imem_req_valid); end
    n_checks++; if (imem_req_addr !== RST_PC) begin n_errors++; $display("FAIL reset_req_addr: got %h want %h", imem_req_addr, RST_PC); end
    n_checks++; if (inst_valid !== 1'b0) begin n_errors++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
    n_checks++; if (inst !== 32'h0) begin n_errors++; $display("FAIL reset_inst: got %h want 0", inst); end
    n_checks++; if (inst_pc !== 64'h0) begin n_errors++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
    n_checks++; if (misalign !== 1'b0) begin n_errors++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    rst = 1'b1;
    exp_pc = RST_PC;
  endtask

  task automatic test_first_fetch();
    n_checks++; if (imem_req_addr !== 64'h8000_0000) begin n_errors++; $display("FAIL first_addr: got %h want 80000000", imem_req_addr); end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0073;
    n_checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_errors++; $display("FAIL first_wait: got req %b inst %b want 0 0", imem_req_valid, inst_valid); end
    @(negedge clk);
    imem_resp_valid = 1'b0;
    n_checks++; if (inst_valid !== 1'b1) begin n_errors++; $display("FAIL first_inst_valid: got %b want 1", inst_valid); end
    n_checks++; if (inst !== 32'h0010_0073) begin n_errors++; $display("FAIL first_inst: got %h want 00100073", inst); end
    n_checks++; if (inst_pc !== 64'h8000_0000) begin n_errors++; $display("FAIL first_inst_pc: got %h want 80000000", inst_pc); end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    exp_pc = exp_pc + 64'd4;
  endtask

  task automatic test_stream();
    logic [31:0] word;
    for (int i = 0; i < 3; i++) begin
      word = 32'h0000_0013 | (32'(i) << 20);
      n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin n_errors++; $display("FAIL stream_req%0d: got v=%b addr=%h want v=1 addr=%h", i, imem_req_valid, imem_req_addr, exp_pc); end
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = word;
      @(negedge clk);
      imem_resp_valid = 1'b0;
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== word) begin n_errors++; $display("FAIL stream_out%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", i, inst_valid, inst_pc, inst, exp_pc, word); end
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      exp_pc = exp_pc + 64'd4;
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hcafe_0093;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (inst_valid !== 1'b1 || inst !== 32'hcafe_0093 || inst_pc !== exp_pc || imem_req_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL bp_stall: got %0d unstable cycles want 0", bad); end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    exp_pc = exp_pc + 64'd4;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc || inst_valid !== 1'b0) begin n_errors++; $display("FAIL bp_release: got v=%b addr=%h iv=%b want v=1 addr=%h iv=0", imem_req_valid, imem_req_addr, inst_valid, exp_pc); end
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hdead_beef;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL rw_still_wait: got req_valid %b want 0", imem_req_valid); end
    @(negedge clk);
    imem_resp_valid = 1'b0;
    exp_pc = 64'h8000_0100;
    n_checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin n_errors++; $display("FAIL rw_next_req: got iv=%b v=%b addr=%h want iv=0 v=1 addr=%h", inst_valid, imem_req_valid, imem_req_addr, exp_pc); end
  endtask

  task automatic test_redirect_wait_resp();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;
    @(negedge clk);
    redirect_valid = 1'b0; imem_resp_valid = 1'b0;
    exp_pc = 64'h8000_0200;
    n_checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin n_errors++; $display("FAIL rwr_next_req: got iv=%b v=%b addr=%h want iv=0 v=1 addr=%h", inst_valid, imem_req_valid, imem_req_addr, exp_pc); end
  endtask

  task automatic test_redirect_req_hs();
    imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
    @(negedge clk);
    imem_req_ready = 1'b0; redirect_valid = 1'b0;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_errors++; $display("FAIL rrh_wait: got req_valid %b want 0", imem_req_valid); end
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0bad_0bad;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    exp_pc = 64'h8000_0300;
    n_checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin n_errors++; $display("FAIL rrh_next_req: got iv=%b v=%b addr=%h want iv=0 v=1 addr=%h", inst_valid, imem_req_valid, imem_req_addr, exp_pc); end
  endtask

  task automatic test_redirect_out();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_006f;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc) begin n_errors++; $display("FAIL ro_out: got iv=%b pc=%h want iv=1 pc=%h", inst_valid, inst_pc, exp_pc); end
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0040;
    @(negedge clk);
    inst_ready = 1'b0; redirect_valid = 1'b0;
    exp_pc = 64'h8000_0040;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin n_errors++; $display("FAIL ro_next_req: got v=%b addr=%h want v=1 addr=%h", imem_req_valid, imem_req_addr, exp_pc); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 64'hffff_ffff_ffff_fffc;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hffff_ffff_ffff_fffc) begin n_errors++; $display("FAIL wrap_req: got v=%b addr=%h want v=1 addr=fffffffffffffffc", imem_req_valid, imem_req_addr); end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0013;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    n_checks++; if (inst_pc !== 64'hffff_ffff_ffff_fffc) begin n_errors++; $display("FAIL wrap_inst_pc: got %h want fffffffffffffffc", inst_pc); end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    exp_pc = 64'h0;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin n_errors++; $display("FAIL wrap_next: got v=%b addr=%h want v=1 addr=0", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_align();
    int bad = 0;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef YSYX_22050039_IFU_ALIGN_CHECK_EN
    imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (misalign !== 1'b1 || imem_req_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    imem_req_ready = 1'b0;
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL align_fault: got %0d cycles without fault want 0", bad); end
`else
    n_checks++; if (misalign !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0002) begin n_errors++; $display("FAIL align_pass: got m=%b v=%b addr=%h want m=0 v=1 addr=80000002", misalign, imem_req_valid, imem_req_addr); end
`endif
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0010;
    @(negedge clk);
    redirect_valid = 1'b0;
    exp_pc = 64'h8000_0010;
    n_checks++; if (misalign !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin n_errors++; $display("FAIL align_recover: got m=%b v=%b addr=%h want m=0 v=1 addr=%h", misalign, imem_req_valid, imem_req_addr, exp_pc); end
  endtask

  task automatic test_reset_mid();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || inst_valid !== 1'b0) begin n_errors++; $display("FAIL reset_mid: got v=%b addr=%h iv=%b want v=1 addr=%h iv=0", imem_req_valid, imem_req_addr, inst_valid, RST_PC); end
    @(negedge clk);
    rst = 1'b1;
    exp_pc = RST_PC;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_wait_resp();
    test_redirect_req_hs();
    test_redirect_out();
    test_wrap();
    test_align();
    test_reset_mid();
    test_first_fetch();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050039_ifu.md
# ysyx_22050039_ifu

Multi-cycle instruction fetch unit for the single-issue RV64 core. It holds the architectural PC, issues instruction-memory reads over a valid/ready request channel, and hands each fetched instruction with its PC to decode over a valid/ready channel. It sits at the opposite end of the execute stage's next-PC output: it consumes `dnpc` as a redirect and turns it into the next fetch address.

## Interface

**Parameters**
- `XLEN`, default 64: PC and address width.
- `RESET_PC`, default 64'h8000_0000: PC value loaded at reset.

**Ports**
- `clk` input 1: single clock. Everything is sampled on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `imem_req_valid` output 1: a fetch request is presented.
- `imem_req_ready` input 1: memory accepts the request.
- `imem_req_addr` output XLEN: fetch address, equal to the current PC.
- `imem_resp_valid` input 1: read data is valid. It is always accepted; there is no backpressure.
- `imem_resp_data` input 32: the fetched instruction word.
- `inst_valid` output 1: an instruction is offered to decode.
- `inst_ready` input 1: decode accepts the instruction.
- `inst` output 32: the instruction word.
- `inst_pc` output XLEN: the PC of `inst`.
- `redirect_valid` input 1: the execute stage supplies a new PC.
- `redirect_pc` input XLEN: the redirect target (`dnpc`).
- `misalign` output 1: misaligned-fetch fault. Tied to 0 unless the macro below is defined.

## Operation

**Reset state.** `state`=S_REQ, `pc`=RESET_PC, `inst`=0, `kill`=0. All outputs read 0 except `imem_req_valid`=1 and `imem_req_addr`=RESET_PC.

**States**
- S_REQ: drives `imem_req_valid`=1 with `imem_req_addr`=`pc`. On `imem_req_ready`, go to S_WAIT.
- S_WAIT: waits for the response. On `imem_resp_valid`:
  - if `kill`=0, capture the word into `inst` and go to S_OUT;
  - if `kill`=1, discard the word, clear `kill` and go to S_REQ.
- S_OUT: drives `inst_valid`=1 with `inst` and `inst_pc`=`pc`. On `inst_ready`, set `pc` to `pc`+4 and go to S_REQ.
- S_FAULT: exists only with the macro defined. See Configuration.

**Arithmetic.** `pc`+4 wraps modulo 2^XLEN; no carry out.

**Redirect** has top priority in every state. `pc` always takes `redirect_pc`.
- In S_REQ without a handshake: stay in S_REQ. The new address appears on the next cycle.
- In S_REQ with a handshake in the same cycle: go to S_WAIT with `kill`=1.
- In S_WAIT with no response this cycle: set `kill`=1 and stay.
- In S_WAIT with a response this cycle: discard the data and go to S_REQ.
- In S_OUT: the held instruction is dropped, or counts as consumed if `inst_ready` is also high. Either way `pc` is not incremented, and the next state is S_REQ.

**Request ordering.** Only one request is outstanding at a time. `imem_resp_valid` seen outside S_WAIT is ignored.

**Reset mid-operation.** An asynchronous reset returns to the reset state immediately. A response still in flight is the memory model's responsibility.

## Timing

- Best case is 3 cycles per instruction: REQ handshake in cycle n, response in n+1, `inst_valid` in n+2, next request in n+3.
- Outputs are registered or decoded from state only. There is no combinational path from any input to `imem_req_*` or `inst_valid`.
- `inst` and `inst_pc` stay stable while `inst_valid`=1 and `inst_ready`=0.
- `imem_req_addr` changes only on redirect or state change.

## Configuration

`YSYX_22050039_IFU_ALIGN_CHECK_EN`
- **Defined:** on entry to S_REQ, if `pc`[1:0] != 0, no request is issued. The unit enters S_FAULT, where `misalign`=1 and `imem_req_valid`=0. It stays there until `redirect_valid`, which loads `redirect_pc` and returns to S_REQ, re-checking alignment.
- **Undefined:** there is no S_FAULT state, `misalign` is tied to 0, and the low PC bits pass to `imem_req_addr` unchanged.

## Structure

- Shared package `ysyx_22050039_pkg` holds:
  - the state enum (S_REQ, S_WAIT, S_OUT, S_FAULT);
  - `INST_W`=32;
  - the default RESET_PC constant.
- One natural sub-module: `ysyx_22050039_reg(WIDTH, RESET_VAL)`, an async-active-low-reset register with enable. It is instantiated for `pc`, `inst` and `kill`.

## Test plan

1. **Reset and first fetch.** Release reset with `imem_req_ready`=1 and the response `0x00100073` one cycle later. Expect `imem_req_addr`=0x8000_0000 in cycle 0, then `inst_valid` with `inst`=0x00100073 and `inst_pc`=0x8000_0000 in cycle 2.
2. **Sequential stream.** Hold `inst_ready`=1 for three fetches. Expect `inst_pc` = 0x8000_0000, 0x8000_0004, 0x8000_0008, each 3 cycles apart.
3. **Decode backpressure.** Hold `inst_ready`=0 for 5 cycles in S_OUT. Expect `inst` and `inst_pc` stable and no new request; `imem_req_valid` rises the cycle after `inst_ready`=1.
4. **Redirect in S_WAIT.** Pulse `redirect_valid` with `redirect_pc`=0x8000_0100 while waiting. Expect the old response discarded (no `inst_valid`) and the next request at 0x8000_0100.
5. **Redirect with an S_OUT handshake in the same cycle.** With `redirect_pc`=0x8000_0040, expect the next `imem_req_addr`=0x8000_0040, not `pc`+4.
6. **Alignment fault (macro defined).** Redirect to 0x8000_0002. Expect `misalign`=1 and `imem_req_valid`=0 until a redirect to 0x8000_0010, which clears `misalign` and issues the request.
